// File: rtl/gest_interrup_n_pkg.sv
// Shared definitions for the interrupt controller: FSM encodings, default vectors,
// and the vector-address helper used by the PC-select and decoder logic.
package gest_interrup_n_pkg;

  localparam int unsigned ID_W           = 4;
  localparam int unsigned MAX_IRQ        = 16;
  localparam int unsigned DEF_VEC_BASE   = 824;
  localparam int unsigned DEF_VEC_STRIDE = 50;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_SERVICE  = 2'd2
  } state_t;

  // Vector of line id, computed in 32 bits; callers truncate to their address width.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [ID_W-1:0] id);
    return base + 32'(id) * stride;
  endfunction

endpackage

// File: rtl/gest_interrup_n_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
module gest_interrup_n_prio_enc
  import gest_interrup_n_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               any_c,
  output logic [ID_W-1:0]    idx_c
);

  // Scan from the top down so the lowest index is the last one written.
  always_comb begin
    any_c = |req;
    idx_c = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) idx_c = ID_W'(i);
    end
  end

endmodule

// File: rtl/gest_interrup_n.sv
// Interrupt controller: rising-edge request latching, per-line mask, and a
// non-nesting dispatch FSM that issues a one-cycle vector load to the CPU.
module gest_interrup_n
  import gest_interrup_n_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned VEC_BASE   = DEF_VEC_BASE,
  parameter int unsigned VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] iport,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_in,
  input  logic               fin,
  output logic               s_interrup,
  output logic [ADDR_W-1:0]  dir,
  output logic               active,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] pending
);

  if (NUM_IRQ < 1 || NUM_IRQ > MAX_IRQ) begin : g_bad_num_irq
    $error("gest_interrup_n: NUM_IRQ must be in 1..16");
  end
  if ((64'(VEC_BASE) + 64'(NUM_IRQ - 1) * 64'(VEC_STRIDE)) >= (64'(1) << ADDR_W))
  begin : g_bad_vec
    $error("gest_interrup_n: highest vector does not fit in ADDR_W");
  end

  state_t               state, state_nxt;
  logic [NUM_IRQ-1:0]   prev_iport;
  logic [NUM_IRQ-1:0]   mask;
  logic [NUM_IRQ-1:0]   rise_c;
  logic [NUM_IRQ-1:0]   clr_c;
  logic                 any_c;
  logic [ID_W-1:0]      sel_c;
  logic                 s_nxt;
  logic                 active_nxt;
  logic [ADDR_W-1:0]    dir_nxt;
  logic [ID_W-1:0]      id_nxt;

  assign rise_c = iport & ~prev_iport;

  gest_interrup_n_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .req   (pending & mask),
    .any_c (any_c),
    .idx_c (sel_c)
  );

  // Lines already high at reset are absorbed here so they never look like edges.
  always_ff @(posedge clk) begin
    prev_iport <= iport;
  end

  // A new edge wins over the clear of the line being dispatched.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_c) | rise_c;
  end

  always_ff @(posedge clk) begin
    if (reset)        mask <= '1;
    else if (mask_we) mask <= mask_in;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_interrup <= 1'b0;
      active     <= 1'b0;
      dir        <= '0;
      irq_id     <= '0;
    end else begin
      s_interrup <= s_nxt;
      active     <= active_nxt;
      dir        <= dir_nxt;
      irq_id     <= id_nxt;
    end
  end

  // Next-state and next-output logic; outputs are registered one cycle ahead.
  always_comb begin
    state_nxt  = state;
    s_nxt      = 1'b0;
    active_nxt = active;
    dir_nxt    = dir;
    id_nxt     = irq_id;
    clr_c      = '0;
    case (state)
      ST_IDLE: begin
        if (any_c) begin
          state_nxt  = ST_DISPATCH;
          s_nxt      = 1'b1;
          active_nxt = 1'b1;
          id_nxt     = sel_c;
          dir_nxt    = ADDR_W'(vec_addr(VEC_BASE, VEC_STRIDE, sel_c));
        end
      end
      ST_DISPATCH: begin
        state_nxt = ST_SERVICE;
        clr_c     = NUM_IRQ'(1) << irq_id;
      end
      ST_SERVICE: begin
        if (fin) begin
          state_nxt  = ST_IDLE;
          active_nxt = 1'b0;
          dir_nxt    = '0;
          id_nxt     = '0;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        active_nxt = 1'b0;
        dir_nxt    = '0;
        id_nxt     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_gest_interrup_n.sv
// Scoreboard bench for gest_interrup_n: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the request/service rules.
module tb_gest_interrup_n;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] iport;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       fin;
  logic       s_interrup;
  logic [9:0] dir;
  logic       active;
  logic [3:0] irq_id;
  logic [3:0] pending;

  gest_interrup_n dut (
    .clk        (clk),
    .reset      (reset),
    .iport      (iport),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .fin        (fin),
    .s_interrup (s_interrup),
    .dir        (dir),
    .active     (active),
    .irq_id     (irq_id),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic       s;
    logic       act;
    logic [3:0] id;
    logic [9:0] dir;
    logic [3:0] pend;
  } status_t;

  typedef struct packed {
    int         cyc;
    logic [3:0] id;
    logic [9:0] dir;
  } disp_t;

  status_t sq[$];
  disp_t   dq[$];
  int      cyc = 0;
  int      checks = 0;
  int      failures = 0;

  // Reference model state: what the controller should hold during the next cycle.
  logic [3:0] m_pend, m_mask, m_prev;
  logic       m_disp, m_busy;
  int         m_id;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int vec_of(input int id);
    return 824 + id * 50;
  endfunction

  task automatic step(input logic [3:0] ip, input logic mwe, input logic [3:0] min,
                      input logic f, input logic rst);
    logic [3:0] rises, cand;
    status_t    st;
    disp_t      d;
    iport = ip; mask_we = mwe; mask_in = min; fin = f; reset = rst;
    if (rst) begin
      m_pend = '0; m_mask = 4'hF; m_prev = ip; m_disp = 1'b0; m_busy = 1'b0; m_id = 0;
    end else begin
      rises  = ip & ~m_prev;
      m_prev = ip;
      if (m_disp) begin
        m_pend = (m_pend & ~(4'b0001 << m_id)) | rises;
        m_disp = 1'b0;
        m_busy = 1'b1;
      end else if (m_busy) begin
        m_pend = m_pend | rises;
        if (f) begin
          m_busy = 1'b0;
          m_id   = 0;
        end
      end else begin
        cand   = m_pend & m_mask;
        m_pend = m_pend | rises;
        if (cand != 4'b0) begin
          for (int i = 3; i >= 0; i--) if (cand[i]) m_id = i;
          m_disp = 1'b1;
          d.cyc = cyc + 1; d.id = 4'(m_id); d.dir = 10'(vec_of(m_id));
          dq.push_back(d);
        end
      end
      if (mwe) m_mask = min;
    end
    st.cyc  = cyc + 1;
    st.s    = m_disp;
    st.act  = m_disp | m_busy;
    st.id   = st.act ? 4'(m_id) : 4'd0;
    st.dir  = st.act ? 10'(vec_of(m_id)) : 10'd0;
    st.pend = m_pend;
    sq.push_back(st);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [3:0] ip, input int n);
    for (int k = 0; k < n; k++) step(ip, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  // Monitor: compares every modelled cycle and every dispatch the DUT presents.
  always @(negedge clk) begin
    status_t st;
    disp_t   d;
    if (sq.size() > 0 && sq[0].cyc == cyc) begin
      st = sq.pop_front();
      checks++;
      if ({s_interrup, active, irq_id, dir, pending} !== {st.s, st.act, st.id, st.dir, st.pend}) begin
        failures++;
        $display("FAIL status cyc=%0d got s=%b act=%b id=%0d dir=%0d pend=%b exp s=%b act=%b id=%0d dir=%0d pend=%b",
                 cyc, s_interrup, active, irq_id, dir, pending, st.s, st.act, st.id, st.dir, st.pend);
      end
    end
    if (s_interrup === 1'b1) begin
      checks++;
      if (dq.size() == 0) begin
        failures++;
        $display("FAIL dispatch cyc=%0d got unexpected id=%0d dir=%0d exp none", cyc, irq_id, dir);
      end else begin
        d = dq.pop_front();
        if (d.cyc != cyc || d.id !== irq_id || d.dir !== dir) begin
          failures++;
          $display("FAIL dispatch got cyc=%0d id=%0d dir=%0d exp cyc=%0d id=%0d dir=%0d",
                   cyc, irq_id, dir, d.cyc, d.id, d.dir);
        end
      end
    end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
      d = dq.pop_front();
      checks++;
      failures++;
      $display("FAIL dispatch_missed cyc=%0d got none exp id=%0d dir=%0d", cyc, d.id, d.dir);
    end
  end

  initial begin
    logic [3:0] ip, mi;
    iport = 4'h0; mask_we = 1'b0; mask_in = 4'h0; fin = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    // T1: line 0 high across reset never fires.
    step(4'b0001, 1'b0, 4'h0, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 4'h0, 1'b0, 1'b1);
    idle(4'b0001, 8);
    // T2: line 2 rises, served, fin returns to idle.
    idle(4'b0101, 6);
    step(4'b0101, 1'b0, 4'h0, 1'b1, 1'b0);
    idle(4'b0101, 3);
    // T3: lines 1 and 3 together; line 1 first, then line 3 after one idle cycle.
    idle(4'b1111, 5);
    step(4'b1111, 1'b0, 4'h0, 1'b1, 1'b0);
    idle(4'b1111, 5);
    step(4'b1111, 1'b0, 4'h0, 1'b1, 1'b0);
    idle(4'b0000, 3);
    // T4: masked line 0 pends, unmasking dispatches it.
    step(4'b0000, 1'b1, 4'b1110, 1'b0, 1'b0);
    idle(4'b0001, 4);
    step(4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0);
    idle(4'b0001, 4);
    // T5: line 0 re-edges while serviced, served again after fin.
    idle(4'b0000, 1);
    idle(4'b0001, 2);
    step(4'b0001, 1'b0, 4'h0, 1'b1, 1'b0);
    idle(4'b0001, 4);
    step(4'b0001, 1'b0, 4'h0, 1'b1, 1'b0);
    idle(4'b0000, 2);
    // T6: reset during service with line 2 pending; fin in idle ignored.
    idle(4'b0001, 4);
    idle(4'b0101, 2);
    step(4'b0101, 1'b0, 4'h0, 1'b0, 1'b1);
    step(4'b0101, 1'b0, 4'h0, 1'b1, 1'b0);
    step(4'b0101, 1'b0, 4'h0, 1'b1, 1'b0);
    idle(4'b0101, 2);
    // Random traffic.
    ip = 4'b0101;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) ip = ip ^ 4'($urandom_range(0, 15));
      mi = 4'($urandom_range(0, 15));
      step(ip, ($urandom_range(0, 15) == 0), mi, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 199) == 0));
    end
    // Drain: keep returning until everything pending has been served.
    for (int n = 0; n < 60; n++) step(ip, 1'b1, 4'hF, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dq.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d undelivered dispatches exp 0", dq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
